accu_frame_sched: RTL and testbench

//  Round-robin scheduler that shares one accumulator datapath among NREQ requesters.
//  - Grants one requester at a time and sums exactly FRAME_LEN of its data beats.
//  - Returns the frame sum, tagged with the requester id, on a valid/ready output.
//  - Sits between sample producers and a downstream consumer of frame sums.

---
 rtl/accu_sched_pkg.sv | 10 +
 rtl/accu_frame_sched_if.sv | 26 ++
 rtl/accu_datapath.sv | 48 ++++
 rtl/accu_frame_sched.sv | 113 +++++++++++
 tb/tb_accu_frame_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accu_sched_pkg.sv
// Shared types and helpers for the round-robin accumulator frame scheduler.
package accu_sched_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} sched_state_e;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accu_frame_sched_if.sv
// Requester and frame-sum handshake bundle for accu_frame_sched.
interface accu_frame_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 24
);
  logic [NREQ-1:0]                         req_valid;
  logic [NREQ*DW-1:0]                      req_data;
  logic [NREQ-1:0]                         req_ready;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [AW-1:0]                           out_sum;
  logic [accu_sched_pkg::id_w(NREQ)-1:0]   out_id;
  logic                                    out_ovf;
  logic                                    busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_sum, out_id, out_ovf, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_sum, out_id, out_ovf, busy
  );
endinterface

// File: rtl/accu_datapath.sv
// Accumulator with sticky carry-out detect. Build with ACCU_SCHED_SAT_EN defined to clamp
// at 2^AW-1 instead of wrapping.
module accu_datapath #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [AW-1:0] acc,
  output logic          ovf
);
  logic [AW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {{(AW + 1 - DW){1'b0}}, d};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      ovf_d = ovf_q | sum[AW];
`ifdef ACCU_SCHED_SAT_EN
      acc_d = sum[AW] ? '1 : sum[AW-1:0];
`else
      acc_d = sum[AW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/accu_frame_sched.sv
// Round-robin scheduler sharing one accumulator among NREQ requesters, FRAME_LEN beats per
// grant. Optional ACCU_SCHED_SAT_EN selects a saturating accumulator.
module accu_frame_sched
  import accu_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 24,
  parameter int unsigned FRAME_LEN = 8
) (
  input logic                clk,
  input logic                rst,
  accu_frame_sched_if.slave  bus
);
  localparam int unsigned IdW  = id_w(NREQ);
  localparam int unsigned CntW = id_w(FRAME_LEN);

  sched_state_e    state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d, ptr_q, ptr_d, pick, cand;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clr, en;
  logic [DW-1:0]   sel_data;
  logic [AW-1:0]   acc;
  logic            ovf;

  // Scan downwards so the requester closest after ptr wins.
  always_comb begin
    pick = ptr_q;
    cand = ptr_q;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = IdW'((int'(ptr_q) + k) % int'(NREQ));
      if (bus.req_valid[cand]) pick = cand;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == IdW'(i)) sel_data = bus.req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = pick;
          ptr_d   = pick;
          cnt_d   = '0;
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.req_valid[grant_q]) begin
          en = 1'b1;
          if (cnt_q == CntW'(FRAME_LEN - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IdW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  accu_datapath #(
    .DW (DW),
    .AW (AW)
  ) u_datapath (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .d   (sel_data),
    .acc (acc),
    .ovf (ovf)
  );

  always_comb begin
    bus.req_ready = (state_q == ACCUM) ? (NREQ'(1) << grant_q) : '0;
    bus.out_valid = (state_q == DONE);
    bus.out_sum   = acc;
    bus.out_id    = grant_q;
    bus.out_ovf   = ovf;
    bus.busy      = (state_q != IDLE);
  end
endmodule

// File: tb/tb_accu_frame_sched.sv
// Randomized self-checking bench for accu_frame_sched with a frame-level round-robin model.
module tb_accu_frame_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 24;
  localparam int unsigned FL   = 8;
  localparam int unsigned SDW  = 8;
  localparam int unsigned SAW  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accu_frame_sched_if #(.NREQ(NREQ), .DW(DW),  .AW(AW))  bus  ();
  accu_frame_sched_if #(.NREQ(NREQ), .DW(SDW), .AW(SAW)) sbus ();

  accu_frame_sched #(.NREQ(NREQ), .DW(DW), .AW(AW), .FRAME_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  accu_frame_sched #(.NREQ(NREQ), .DW(SDW), .AW(SAW), .FRAME_LEN(FL)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  logic [DW-1:0]   mem [NREQ][64];
  int              rd  [NREQ];
  int              len [NREQ];
  int              vmode;
  bit              tog, oready_fix, oready_rand;
  logic [NREQ-1:0] ready_allow;
  int              beats, first_beat, last_beat, ov_cycles, bad_mask, bad_onehot;

  int                cap_id [$];
  longint unsigned   cap_sum[$];
  bit                cap_ovf[$];
  int                cap_cyc[$];
  int                exp_id [$];
  longint unsigned   exp_sum[$];
  bit                exp_ovf[$];

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned model_sum(input longint unsigned raw, input int unsigned aw);
    longint unsigned lim;
    lim = (64'd1 << aw) - 1;
`ifdef ACCU_SCHED_SAT_EN
    return (raw > lim) ? lim : raw;
`else
    return raw & lim;
`endif
  endfunction

  // Round-robin at frame granularity: every requester with frames left is always asking.
  task automatic build_expect();
    int rem[NREQ];
    int used[NREQ];
    int ptr, pick, c;
    longint unsigned s;
    exp_id.delete(); exp_sum.delete(); exp_ovf.delete();
    ptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]  = len[i] / FL;
      used[i] = 0;
    end
    forever begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (ptr + k) % NREQ;
        if (pick < 0 && rem[c] > 0) pick = c;
      end
      if (pick < 0) break;
      s = 0;
      for (int b = 0; b < FL; b++) s += mem[pick][used[pick]*FL + b];
      exp_id.push_back(pick);
      exp_sum.push_back(model_sum(s, AW));
      exp_ovf.push_back(s > ((64'd1 << AW) - 1));
      used[pick]++;
      rem[pick]--;
      ptr = pick;
    end
  endtask

  task automatic drive();
    bit on;
    for (int i = 0; i < NREQ; i++) begin
      on = rd[i] < len[i];
      case (vmode)
        1:       on = on && tog;
        2:       on = on && ($urandom_range(99) >= 30);
        default: ;
      endcase
      bus.req_valid[i]         = on;
      bus.req_data[i*DW +: DW] = (rd[i] < len[i]) ? mem[i][rd[i]] : '0;
    end
    bus.out_ready = oready_rand ? ($urandom_range(1) == 1) : oready_fix;
  endtask

  task automatic clear_stats();
    cap_id.delete(); cap_sum.delete(); cap_ovf.delete(); cap_cyc.delete();
    beats = 0; first_beat = -1; last_beat = -1; ov_cycles = 0; bad_mask = 0;
  endtask

  task automatic tick();
    logic [NREQ-1:0] fire;
    @(negedge clk);
    fire = bus.req_valid & bus.req_ready;
    if ($countones(bus.req_ready) > 1) bad_onehot++;
    if ((bus.req_ready & ~ready_allow) != '0) bad_mask++;
    if (bus.out_valid) ov_cycles++;
    if (fire != '0) begin
      beats++;
      if (first_beat < 0) first_beat = cyc + 1;
      last_beat = cyc + 1;
    end
    if (bus.out_valid && bus.out_ready) begin
      cap_id.push_back(int'(bus.out_id));
      cap_sum.push_back(bus.out_sum);
      cap_ovf.push_back(bus.out_ovf);
      cap_cyc.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) if (fire[i]) rd[i]++;
    tog = ~tog;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rd[i]  = 0;
      len[i] = 0;
    end
    vmode = 0; oready_fix = 1'b1; oready_rand = 1'b0; tog = 1'b1; ready_allow = '1;
    drive();
    sbus.req_valid = '0; sbus.req_data = '0; sbus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    clear_stats();
  endtask

  task automatic run_until(input int n, input int budget);
    for (int c = 0; c < budget && cap_id.size() < n; c++) tick();
    if (cap_id.size() < n) check("timeout_frames", cap_id.size(), n);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check({tag, "_count"}, cap_id.size(), exp_id.size());
    n = (cap_id.size() < exp_id.size()) ? cap_id.size() : exp_id.size();
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s_id%0d", tag, j),  cap_id[j],  exp_id[j]);
      check($sformatf("%s_sum%0d", tag, j), cap_sum[j], exp_sum[j]);
      check($sformatf("%s_ovf%0d", tag, j), cap_ovf[j], exp_ovf[j]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_ready"}, bus.req_ready, 0);
    check({tag, "_sum"},   bus.out_sum, 0);
    check({tag, "_id"},    bus.out_id, 0);
    check({tag, "_ovf"},   bus.out_ovf, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, sb, r;
    bit got;
    longint unsigned s_sum, tot;
    bit s_ovf;

    bad_onehot = 0;
    rst = 1'b1;
    #1;
    check_idle_outputs("reset");

    // Single requester, back-to-back 1..8.
    do_reset();
    len[0] = FL;
    for (int b = 0; b < FL; b++) mem[0][b] = DW'(b + 1);
    build_expect();
    drive();
    run_until(1, 40);
    repeat (3) tick();
    compare_frames("single");
    if (cap_cyc.size() > 0) check("single_latency", cap_cyc[0], 10);
    check("single_valid_cycles", ov_cycles, 1);
    check("single_idle_after", bus.busy, 0);

    // All requesters continuously valid; requester 0 has two frames.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      len[i] = (i == 0) ? 2 * FL : FL;
      for (int b = 0; b < len[i]; b++) mem[i][b] = DW'(i + 1);
    end
    build_expect();
    drive();
    run_until(5, 200);
    compare_frames("rr");

    // Requester 2 alone with valid toggling every cycle.
    do_reset();
    len[2] = FL;
    for (int b = 0; b < FL; b++) mem[2][b] = DW'(5);
    vmode = 1; ready_allow = 4'b0100;
    build_expect();
    drive();
    run_until(1, 60);
    compare_frames("stall");
    check("stall_beats", beats, FL);
    check("stall_span", last_beat - first_beat + 1, 2 * FL - 1);
    check("stall_other_ready", bad_mask, 0);

    // Output backpressure on requester 1.
    do_reset();
    len[1] = FL;
    for (int b = 0; b < FL; b++) mem[1][b] = DW'($urandom);
    oready_fix = 1'b0;
    build_expect();
    drive();
    for (int n = 0; n < 40 && !bus.out_valid; n++) tick();
    check("bp_valid", bus.out_valid, 1);
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.out_sum !== exp_sum[0] || bus.out_id !== 2'd1 || !bus.busy ||
          bus.req_ready !== '0 || !bus.out_valid) bad++;
    end
    check("bp_hold", bad, 0);
    oready_fix = 1'b1;
    drive();
    tick();
    check("bp_idle_busy", bus.busy, 0);
    check("bp_idle_valid", bus.out_valid, 0);
    compare_frames("bp");

    // Overflow on the narrow instance: eight beats of 255.
    do_reset();
    sbus.req_valid = 4'b0001;
    sbus.req_data  = '0;
    sbus.req_data[SDW-1:0] = 8'hff;
    sb = 0; got = 1'b0; s_sum = 0; s_ovf = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (sbus.req_valid[0] && sbus.req_ready[0]) sb++;
      if (sbus.out_valid) begin
        got   = 1'b1;
        s_sum = sbus.out_sum;
        s_ovf = sbus.out_ovf;
      end
      @(posedge clk);
      #1;
      if (sb >= FL) sbus.req_valid = '0;
    end
    tot = FL * 255;
    check("ovf_seen", got, 1);
    check("ovf_sum", s_sum, model_sum(tot, SAW));
    check("ovf_flag", s_ovf, 1);

    // Reset asserted after three beats, then a fresh two-way contention.
    do_reset();
    len[0] = FL;
    for (int b = 0; b < FL; b++) mem[0][b] = DW'($urandom_range(1, 65535));
    drive();
    for (int n = 0; n < 30 && beats < 3; n++) tick();
    check("midrst_beats", beats, 3);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    clear_stats();
    for (int i = 0; i < 2; i++) begin
      rd[i]  = 0;
      len[i] = FL;
      for (int b = 0; b < FL; b++) mem[i][b] = DW'($urandom);
    end
    build_expect();
    drive();
    run_until(2, 100);
    compare_frames("midrst_after");

    // Random frame mixes with random output backpressure.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        len[i] = FL * $urandom_range(0, 3);
        for (int b = 0; b < len[i]; b++) mem[i][b] = DW'($urandom);
      end
      if (len[0] + len[1] + len[2] + len[3] == 0) len[$urandom_range(NREQ - 1)] = FL;
      oready_rand = 1'b1;
      build_expect();
      drive();
      run_until(exp_id.size(), 2000);
      compare_frames($sformatf("rand%0d", it));
    end

    // Random valid gaps on one requester.
    do_reset();
    r = $urandom_range(NREQ - 1);
    len[r] = 2 * FL;
    for (int b = 0; b < len[r]; b++) mem[r][b] = DW'($urandom);
    vmode = 2;
    build_expect();
    drive();
    run_until(2, 400);
    compare_frames("gaps");

    check("ready_onehot", bad_onehot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
